// File: rtl/pipe_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_link_pkg
// Description : Shared definitions for the inter-stage pipeline buffer.
//               Holds the stage packet typedefs whose $bits sets PKT_W at each
//               pipe_link instantiation, plus the pointer-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_link_pkg;

    // IF -> ID stage packet
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic        valid;
    } IF_ID_PACKET;

    // ID -> EX stage packet
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [4:0]  dest_reg_idx;
        logic [4:0]  alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        cond_branch;
        logic        uncond_branch;
        logic        halt;
        logic        illegal;
        logic        valid;
    } ID_EX_PACKET;

    // EX -> MEM stage packet
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] npc;
        logic [31:0] rs2_value;
        logic [4:0]  dest_reg_idx;
        logic        take_branch;
        logic        rd_mem;
        logic        wr_mem;
        logic        halt;
        logic        illegal;
        logic        valid;
    } EX_MEM_PACKET;

    // Ring pointer width: max(1, clog2(depth)) so DEPTH=1 still has a bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_link_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ring_ptr
// Description : Wrapping index register for a DEPTH-entry circular buffer.
//               Wraps by explicit compare against DEPTH-1, so DEPTH need not
//               be a power of two.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset (ptr -> 0)
//               inc  - advance pointer by one (wrapping)
//               clr  - synchronous clear to 0, dominates inc
//               ptr  - current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module ring_ptr
    import pipe_link_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/pipe_link.sv
`default_nettype none
// ============================================================================
// Module      : pipe_link
// Description : Elastic valid/ready buffer placed between pipeline stages.
//               DEPTH-entry circular FIFO of opaque PKT_W-bit packets with a
//               synchronous flush (branch redirect), an occupancy output and a
//               saturating back-pressure counter.
// Ports       : clk, rst (async active-low)
//               in_valid/in_ready/in_pkt     - upstream handshake
//               out_valid/out_ready/out_pkt  - downstream handshake
//               flush        - drop all held entries at the next edge
//               occupancy    - entries currently held
//               stall_cycles - saturating count of out_valid && !out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_link
    import pipe_link_pkg::*;
#(
    parameter  int PKT_W = 128,
    parameter  int DEPTH = 2,
    parameter  int CNT_W = 32,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_link: DEPTH must be >= 1");
    end

    localparam logic [OCC_W-1:0] C_FULL      = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_STALL_MAX = '1;

    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_stall;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on registered count and flush, so a pop on a full
    // buffer cannot open the input in the same cycle (no ready->ready path).
    assign w_in_ready  = (r_count != C_FULL) && !flush;
    assign w_out_valid = (r_count != '0) && !flush;
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop),
        .clr (flush),
        .ptr (w_rd_ptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push),
        .clr (flush),
        .ptr (w_wr_ptr)
    );

    // Packet storage is deliberately not reset; out_pkt masks stale data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && (r_stall != C_STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_pkt      = w_out_valid ? r_mem[w_rd_ptr] : '0;
    assign occupancy    = r_count;
    assign stall_cycles = r_stall;

endmodule
`default_nettype wire
